// File: rtl/function_unit_mc.sv
// Multi-cycle function unit: base ALU/shift/compare ops with a one-cycle
// registered result, and RV32M multiply/divide run iteratively one bit per
// cycle. Both sides use a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   md, fs              op select: md=0 base op (fs), md=1 M op (fs[2:0])
//   a, b                operands, captured on the accept edge
//   out_valid/out_ready result handshake; s and zcnv are held while waiting
//   s, zcnv             result and flags {Z,C,N,V}
module function_unit_mc #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            md,
    input  logic [3:0]      fs,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] s,
    output logic [3:0]      zcnv
);

    localparam int unsigned CW  = $clog2(XLEN + 1);
    localparam int unsigned MSB = XLEN - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;     // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;     // multiplier->product low / dividend->quotient
    logic [XLEN-1:0]   dv_q, dv_d;     // multiplicand / divisor magnitude
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;   // negate the selected result on the last step
    logic [XLEN-1:0]   s_q, s_d;
    logic [3:0]        zcnv_q, zcnv_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    // Base ALU: result and flags, valid on the accept edge
    logic [XLEN:0]   add_w, sub_w;
    logic [XLEN-1:0] base_s;
    logic            base_c, base_v, base_ok;
    logic [3:0]      base_f;

    always_comb begin : base_alu
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} + {1'b0, ~b} + (XLEN + 1)'(1);
        base_s  = '0;
        base_c  = 1'b0;
        base_v  = 1'b0;
        base_ok = 1'b1;
        case (fs)
            4'b0000: begin
                base_s = add_w[MSB:0];
                base_c = add_w[XLEN];
                base_v = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
            end
            4'b0001: begin
                base_s = sub_w[MSB:0];
                base_c = sub_w[XLEN];
                base_v = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
            end
            4'b0010: base_s = a << b[SHW-1:0];
            4'b0100: base_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0110: base_s = {{(XLEN-1){1'b0}}, (a < b)};
            4'b1000: base_s = a ^ b;
            4'b1010: base_s = a >> b[SHW-1:0];
            4'b1011: base_s = $signed(a) >>> b[SHW-1:0];
            4'b1100: base_s = a | b;
            4'b1110: base_s = a & b;
            default: base_ok = 1'b0;
        endcase
        // Undefined codes report no flags at all, Z included
        base_f = base_ok ? {(base_s == '0), base_c, base_s[MSB], base_v} : 4'b0000;
    end

    // M-op setup: operands reduced to magnitudes plus the result sign
    logic            a_sgn, b_sgn, an, bn;
    logic [XLEN-1:0] amag, bmag;

    always_comb begin : m_setup
        a_sgn = (fs[2:0] == 3'b001) || (fs[2:0] == 3'b010) ||
                (fs[2:0] == 3'b100) || (fs[2:0] == 3'b110);
        b_sgn = (fs[2:0] == 3'b001) || (fs[2:0] == 3'b100) || (fs[2:0] == 3'b110);
        an    = a_sgn && a[MSB];
        bn    = b_sgn && b[MSB];
        amag  = an ? (~a + XLEN'(1)) : a;
        bmag  = bn ? (~b + XLEN'(1)) : b;
    end

    // One iteration: shift-add multiply or restoring divide
    logic [XLEN:0]     msum, dt, ddiff;
    logic              qbit;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   div_sel, m_res;

    always_comb begin : m_step
        msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
        dt    = {hi_q, lo_q[MSB]};
        ddiff = dt - {1'b0, dv_q};
        qbit  = ~ddiff[XLEN];
        if (op_q[2]) begin
            step_hi = qbit ? ddiff[MSB:0] : dt[MSB:0];
            step_lo = {lo_q[XLEN-2:0], qbit};
        end else begin
            step_hi = msum[XLEN:1];
            step_lo = {msum[0], lo_q[XLEN-1:1]};
        end
        prod    = {step_hi, step_lo};
        prod_f  = neg_q ? (~prod + (2 * XLEN)'(1)) : prod;
        div_sel = op_q[1] ? step_hi : step_lo;
        if (op_q[2]) begin
            m_res = neg_q ? (~div_sel + XLEN'(1)) : div_sel;
        end else if (op_q[1:0] == 2'b00) begin
            m_res = prod_f[XLEN-1:0];
        end else begin
            m_res = prod_f[2*XLEN-1:XLEN];
        end
    end

    // Next-state and registered-output logic
    always_comb begin : next_state
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dv_d        = dv_q;
        op_d        = op_q;
        neg_d       = neg_q;
        s_d         = s_q;
        zcnv_d      = zcnv_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (!md) begin
                        s_d         = base_s;
                        zcnv_d      = base_f;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        op_d    = fs[2:0];
                        cnt_d   = CW'(XLEN);
                        hi_d    = '0;
                        state_d = BUSY;
                        if (fs[2]) begin
                            lo_d  = amag;
                            dv_d  = bmag;
                            // x/0 quotient stays all ones; remainder follows the dividend
                            neg_d = fs[1] ? an : ((an ^ bn) && (b != '0));
                        end else begin
                            lo_d  = bmag;
                            dv_d  = amag;
                            neg_d = an ^ bn;
                        end
                    end
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    s_d         = m_res;
                    zcnv_d      = {(m_res == '0), 1'b0, m_res[MSB], 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            dv_q        <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            s_q         <= '0;
            zcnv_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dv_q        <= dv_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            s_q         <= s_d;
            zcnv_q      <= zcnv_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign zcnv      = zcnv_q;

endmodule

// File: tb/tb_function_unit_mc.sv
// Bench for function_unit_mc: a 32-bit and a 16-bit instance share operand
// inputs and are checked against an arithmetic reference model.
module tb_function_unit_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md;
    logic [3:0]  fs;
    logic [31:0] a, b;
    logic        out_ready;

    logic        iv32, ir32, ov32;
    logic [31:0] s32;
    logic [3:0]  f32;
    logic        iv16, ir16, ov16;
    logic [15:0] s16;
    logic [3:0]  f16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function_unit_mc #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .md(md), .fs(fs), .a(a), .b(b), .out_valid(ov32),
        .out_ready(out_ready), .s(s32), .zcnv(f32)
    );

    function_unit_mc #(.XLEN(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .md(md), .fs(fs), .a(a[15:0]), .b(b[15:0]), .out_valid(ov16),
        .out_ready(out_ready), .s(s16), .zcnv(f16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: RV32I/M semantics evaluated with 64-bit integer arithmetic
    function automatic void model(input int w, input logic m, input logic [3:0] f,
                                  input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] es, output logic [3:0] ef);
        longint mask, ua, ub, sa, sb, minv, maxv, r, t;
        longint unsigned pu;
        bit c, v, ok;
        int sh;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = av[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = bv[w-1] ? ub - (longint'(1) << w) : ub;
        minv = -(longint'(1) << (w - 1));
        maxv = (longint'(1) << (w - 1)) - 1;
        sh   = int'(ub & longint'(w - 1));
        c = 0; v = 0; ok = 1; r = 0;
        if (!m) begin
            case (f)
                4'd0:  begin r = ua + ub; c = ((r >> w) & 1) != 0; t = sa + sb; v = (t > maxv) || (t < minv); end
                4'd1:  begin r = ua - ub; c = (ua >= ub); t = sa - sb; v = (t > maxv) || (t < minv); end
                4'd2:  r = ua << sh;
                4'd4:  r = (sa < sb) ? 1 : 0;
                4'd6:  r = (ua < ub) ? 1 : 0;
                4'd8:  r = ua ^ ub;
                4'd10: r = ua >> sh;
                4'd11: r = sa >>> sh;
                4'd12: r = ua | ub;
                4'd14: r = ua & ub;
                default: ok = 0;
            endcase
        end else begin
            case (f[2:0])
                3'd0: r = ua * ub;
                3'd1: r = (sa * sb) >>> w;
                3'd2: r = (sa * ub) >>> w;
                3'd3: begin pu = longint'(ua) * longint'(ub); r = longint'(pu >> w); end
                3'd4: r = (ub == 0) ? -1 : ((sa == minv && sb == -1) ? sa : sa / sb);
                3'd5: r = (ub == 0) ? -1 : ua / ub;
                3'd6: r = (ub == 0) ? sa : ((sa == minv && sb == -1) ? 0 : sa % sb);
                default: r = (ub == 0) ? ua : ua % ub;
            endcase
        end
        r  = r & mask;
        es = 32'(r);
        ef = ok ? {(r == 0), c, (((r >> (w - 1)) & 1) != 0), v} : 4'b0000;
    endfunction

    // Issue one op to the chosen instance, wait for its result, check it
    task automatic run_op(input bit w16, input logic m, input logic [3:0] f,
                          input logic [31:0] av, input logic [31:0] bv,
                          input string tag, input bit has_exp, input logic [31:0] exp_s);
        logic [31:0] es, got_s;
        logic [3:0]  ef, got_f;
        int lat, w;
        w = w16 ? 16 : 32;
        model(w, m, f, av, bv, es, ef);
        md = m; fs = f; a = av; b = bv; out_ready = 1'b1;
        check({tag, " ready"}, w16 ? ir16 : ir32, 1'b1);
        if (w16) iv16 = 1'b1; else iv32 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0; iv32 = 1'b0;
        a = $urandom; b = $urandom; fs = 4'($urandom); md = 1'($urandom);
        lat = 1;
        while (!(w16 ? ov16 : ov32) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        got_s = w16 ? {16'h0, s16} : s32;
        got_f = w16 ? f16 : f32;
        check({tag, " latency"}, lat, m ? w + 1 : 1);
        check({tag, " s"}, got_s, es);
        check({tag, " zcnv"}, got_f, ef);
        if (has_exp) check({tag, " s_lit"}, got_s, exp_s);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mk;
        mk = (w == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return mk;
            3: return (w == 16) ? 32'h8000 : 32'h8000_0000;
            4: return mk >> 1;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom & mk;
        endcase
    endfunction

    initial begin
        int lat;
        rst_n = 1'b0; iv32 = 1'b0; iv16 = 1'b0;
        md = 1'b0; fs = '0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", ir32, 1'b1);
        check("rst out_valid", ov32, 1'b0);
        check("rst s", s32, 32'h0);
        check("rst zcnv", f32, 4'h0);
        check("rst16 in_ready", ir16, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a divide
        md = 1'b1; fs = 4'b0100; a = 32'd100; b = 32'd7; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        check("middiv busy", ir32, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("middiv in_ready", ir32, 1'b1);
        check("middiv out_valid", ov32, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 0, 4'b0000, 32'd1, 32'd2, "add after rst", 1, 32'd3);

        run_op(0, 0, 4'b0000, 32'h7FFF_FFFF, 32'd1, "add ovf", 1, 32'h8000_0000);
        run_op(0, 0, 4'b0001, 32'd5, 32'd5, "sub eq", 1, 32'h0);
        run_op(0, 0, 4'b1011, 32'h8000_0000, 32'd31, "sra", 1, 32'hFFFF_FFFF);
        run_op(0, 0, 4'b0101, 32'd3, 32'd4, "undef fs", 1, 32'h0);
        run_op(0, 1, 4'b0001, 32'hFFFF_FFFF, 32'd2, "mulh", 1, 32'hFFFF_FFFF);
        run_op(0, 1, 4'b0011, 32'hFFFF_FFFF, 32'd2, "mulhu", 1, 32'h1);
        run_op(0, 1, 4'b0000, 32'hFFFF_FFFF, 32'd2, "mul", 1, 32'hFFFF_FFFE);
        run_op(0, 1, 4'b0100, 32'hFFFF_FFF9, 32'd2, "div -7/2", 1, 32'hFFFF_FFFD);
        run_op(0, 1, 4'b0110, 32'hFFFF_FFF9, 32'd2, "rem -7/2", 1, 32'hFFFF_FFFF);
        run_op(0, 1, 4'b0101, 32'd1234, 32'd0, "divu x/0", 1, 32'hFFFF_FFFF);
        run_op(0, 1, 4'b0110, 32'd9, 32'd0, "rem 9/0", 1, 32'd9);
        run_op(0, 1, 4'b0100, 32'hFFFF_FFF9, 32'd0, "div -7/0", 1, 32'hFFFF_FFFF);
        run_op(0, 1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", 1, 32'h8000_0000);
        run_op(0, 1, 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf", 1, 32'h0);

        // Backpressure on a finished MUL
        md = 1'b1; fs = 4'b0000; a = 32'd6; b = 32'd7; out_ready = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", lat, 33);
        for (int i = 0; i < 10; i++) begin
            check("bp s", s32, 32'd42);
            check("bp out_valid", ov32, 1'b1);
            check("bp in_ready", ir32, 1'b0);
            md = 1'b0; fs = 4'b0000; a = 32'd1; b = 32'd1; iv32 = 1'(i % 2);
            @(posedge clk); #1;
        end
        // Release with a new op pending: only DONE->IDLE on this edge
        iv32 = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", ov32, 1'b0);
        check("bp release in_ready", ir32, 1'b1);
        @(posedge clk); #1;
        iv32 = 1'b0;
        check("bp next accept", ov32, 1'b1);
        check("bp next s", s32, 32'd2);
        @(posedge clk); #1;

        // 16-bit instance
        run_op(1, 1, 4'b0101, 32'h0000_FFFF, 32'd3, "x16 divu", 1, 32'h5555);
        run_op(1, 0, 4'b0010, 32'd1, 32'h0000_0013, "x16 sll", 1, 32'h0008);
        run_op(1, 1, 4'b0100, 32'h0000_8000, 32'h0000_FFFF, "x16 div ovf", 1, 32'h8000);

        // Randomized ops against the model
        for (int i = 0; i < 300; i++) begin
            bit       w16;
            logic     m;
            logic [3:0] f;
            w16 = (i >= 200);
            m   = 1'($urandom);
            f   = m ? {1'b0, 3'($urandom)} : 4'($urandom);
            run_op(w16, m, f, pick(w16 ? 16 : 32), pick(w16 ? 16 : 32), "rand", 0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
